// File: rtl/tx_pack_arb_pkg.sv
// Shared definitions for the tx_pack packet arbiter: state encoding and width helper.
package tx_pack_arb_pkg;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r == 0) ? 1 : r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/tx_pack_arb_pkt_rr_pick.sv
// Rotate-priority picker: first requester after `last`, wrapping modulo N_CH.
module pkt_rr_pick
  import tx_pack_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic            any,
  output logic [CH_W-1:0] idx
);

  int pos;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    any = |req;
    idx = '0;
    pos = 0;
    for (int k = N_CH; k >= 1; k--) begin
      pos = (int'(last) + k) % N_CH;
      for (int j = 0; j < N_CH; j++)
        if (j == pos && req[j]) idx = CH_W'(j);
    end
  end

endmodule

// File: rtl/tx_pack_arb.sv
// Packet-level round-robin arbiter feeding one tx_pack packer; one packet in flight,
// header ports held from grant until the packer reports that packet's eop.
module tx_pack_arb
  import tx_pack_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 16,
  parameter int CH_W      = clogb2(N_CH),
  parameter int TO_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]          ch_sop,
  input  logic [N_CH-1:0]          ch_eop,
  input  logic [N_CH-1:0]          ch_mty,
  input  logic [N_CH-1:0]          ch_vld,
  output logic [N_CH-1:0]          ch_rdy,
  input  logic [N_CH*16-1:0]       sport_tbl,
  input  logic [N_CH*16-1:0]       dport_tbl,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_sop,
  output logic                     tx_eop,
  output logic                     tx_mty,
  output logic                     tx_vld,
  input  logic                     tx_rdy,
  output logic [15:0]              cfg_sport,
  output logic [15:0]              cfg_dport,
  input  logic                     pkt_done,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy,
  output logic [N_CH-1:0]          err_proto,
  output logic                     timeout
);

  localparam int             WD_W   = clogb2(TO_CYCLES + 1);
  localparam bit             WD_EN  = (TO_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            cur_ch_q, cur_ch_d, last_q, last_d;
  logic [15:0]                sport_q, sport_d, dport_q, dport_d;
  logic [N_CH-1:0]            err_q, err_d;
  logic                       to_q, to_d;
  logic [WD_W-1:0]            wd_q, wd_d;

  logic [N_CH-1:0][DATA_W-1:0] data_a;
  logic [N_CH-1:0][15:0]       sport_a, dport_a;
  logic [N_CH-1:0]             req, gnt_mask;
  logic                        pick_any, beat_go, eop_go, wd_hit;
  logic [CH_W-1:0]             pick_idx;

  assign data_a  = ch_data;
  assign sport_a = sport_tbl;
  assign dport_a = dport_tbl;
  assign req     = ch_vld & ch_sop;

  pkt_rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign beat_go = (state_q == ST_XFER) && ch_vld[cur_ch_q] && tx_rdy;
  assign eop_go  = beat_go && ch_eop[cur_ch_q];
  assign wd_hit  = WD_EN && (state_q == ST_WAIT) && (wd_q == WD_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // An eop beat leaves XFER before pkt_done is ever looked at, so a coincident
  // pkt_done belongs to no packet of ours and is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_any)             state_d = ST_XFER;
      ST_XFER: if (eop_go)               state_d = ST_WAIT;
      ST_WAIT: if (pkt_done || wd_hit)   state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ch_rdy   = '0;
    gnt_mask = '0;
    tx_vld   = beat_go;
    tx_data  = '0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_mty   = 1'b0;
    if (state_q == ST_XFER) begin
      ch_rdy[cur_ch_q]   = tx_rdy;
      gnt_mask[cur_ch_q] = 1'b1;
    end
    if (beat_go) begin
      tx_data = data_a[cur_ch_q];
      tx_sop  = ch_sop[cur_ch_q];
      tx_eop  = ch_eop[cur_ch_q];
      tx_mty  = ch_mty[cur_ch_q] & ch_eop[cur_ch_q];
    end
  end

  always_comb begin
    cur_ch_d = cur_ch_q;
    last_d   = last_q;
    sport_d  = sport_q;
    dport_d  = dport_q;
    wd_d     = wd_q;
    err_d    = err_q | (ch_vld & ~ch_sop & ~gnt_mask);
    to_d     = wd_hit && !pkt_done;
    if (state_q == ST_IDLE && pick_any) begin
      cur_ch_d = pick_idx;
      last_d   = pick_idx;
      sport_d  = sport_a[pick_idx];
      dport_d  = dport_a[pick_idx];
    end
    if (eop_go)
      wd_d = '0;
    else if (WD_EN && state_q == ST_WAIT)
      wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q <= '0;
      last_q   <= CH_W'(N_CH - 1);
      sport_q  <= '0;
      dport_q  <= '0;
      err_q    <= '0;
      to_q     <= 1'b0;
      wd_q     <= '0;
    end else begin
      cur_ch_q <= cur_ch_d;
      last_q   <= last_d;
      sport_q  <= sport_d;
      dport_q  <= dport_d;
      err_q    <= err_d;
      to_q     <= to_d;
      wd_q     <= wd_d;
    end
  end

  assign cfg_sport = sport_q;
  assign cfg_dport = dport_q;
  assign cur_ch    = cur_ch_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_proto = err_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_tx_pack_arb.sv
// Randomized bench for tx_pack_arb: packet-queue sources, a tx_pack done model and a
// transaction-level reference (round-robin grant, packet phases) checked every cycle.
module tb_tx_pack_arb;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int TO   = 16;
  localparam int MAXP = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*DW-1:0]   ch_data;
  logic [N-1:0]      ch_sop, ch_eop, ch_mty, ch_vld, ch_rdy;
  logic [N*16-1:0]   sport_tbl, dport_tbl;
  logic [DW-1:0]     tx_data;
  logic              tx_sop, tx_eop, tx_mty, tx_vld, tx_rdy, pkt_done;
  logic [15:0]       cfg_sport, cfg_dport;
  logic [1:0]        cur_ch;
  logic              busy, timeout;
  logic [N-1:0]      err_proto;

  tx_pack_arb #(.N_CH(N), .DATA_W(DW), .CH_W(2), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_data(ch_data), .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_mty(ch_mty),
    .ch_vld(ch_vld), .ch_rdy(ch_rdy),
    .sport_tbl(sport_tbl), .dport_tbl(dport_tbl),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_mty(tx_mty),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .cfg_sport(cfg_sport), .cfg_dport(cfg_dport), .pkt_done(pkt_done),
    .cur_ch(cur_ch), .busy(busy), .err_proto(err_proto), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int npkt[N]; int plen[N][MAXP]; bit pmty[N][MAXP]; bit bad[N];
  int pi[N], bi[N];
  int vld_pct, rdy_pct; bit rdy_tog, done_en;
  // Reference: ph 0=no packet owned, 1=packet owned and streaming, 2=waiting for packer eop
  int ph, m_ch, m_last, wcnt, done_cnt, nvld, ntimeout, total;
  bit exp_to; logic [N-1:0] exp_err;
  int grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bdat(input int c, input int p, input int b);
    logic [15:0] r;
    r = {c[1:0], p[5:0], b[7:0]};
    return r;
  endfunction

  function automatic int rr(input int last, input logic [N-1:0] rq);
    for (int k = 1; k <= N; k++)
      if (rq[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  function automatic bit all_done();
    for (int c = 0; c < N; c++)
      if (pi[c] < npkt[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int c, input int len, input bit mty);
    plen[c][npkt[c]] = len;
    pmty[c][npkt[c]] = mty;
    npkt[c]++;
    total += len;
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (bad[c]) begin
        ch_vld[c] = 1'b1; ch_sop[c] = 1'b0; ch_eop[c] = 1'b0; ch_mty[c] = 1'b0;
        ch_data[c*DW +: DW] = 16'hBAD0;
      end else if (pi[c] < npkt[c]) begin
        ch_vld[c] = ($urandom_range(99) < vld_pct);
        ch_sop[c] = (bi[c] == 0);
        ch_eop[c] = (bi[c] == plen[c][pi[c]] - 1);
        ch_mty[c] = ch_eop[c] ? pmty[c][pi[c]] : 1'($urandom_range(1));
        ch_data[c*DW +: DW] = bdat(c, pi[c], bi[c]);
      end else begin
        ch_vld[c] = 1'b0; ch_sop[c] = 1'b0; ch_eop[c] = 1'b0; ch_mty[c] = 1'b0;
        ch_data[c*DW +: DW] = DW'($urandom);
      end
    end
    tx_rdy   = rdy_tog ? ~tx_rdy : ($urandom_range(99) < rdy_pct);
    // Stray pulses outside the wait phase must be ignored by the arbiter.
    pkt_done = done_en && ((done_cnt == 1) || (ph != 2 && $urandom_range(15) == 0));
    if (done_cnt > 0) done_cnt--;
  endtask

  task automatic sample();
    logic [N-1:0] exp_rdy, gmask, rq;
    logic ev, esop, eeop, emty;
    logic [DW-1:0] ed;
    exp_rdy = '0; gmask = '0; ev = 0; esop = 0; eeop = 0; emty = 0; ed = '0;
    if (ph == 1) begin
      gmask[m_ch]   = 1'b1;
      exp_rdy[m_ch] = tx_rdy;
      ev = ch_vld[m_ch] && tx_rdy;
      if (ev) begin
        esop = (bi[m_ch] == 0);
        eeop = (bi[m_ch] == plen[m_ch][pi[m_ch]] - 1);
        emty = eeop && pmty[m_ch][pi[m_ch]];
        ed   = bdat(m_ch, pi[m_ch], bi[m_ch]);
      end
    end
    chk("busy", busy, ph != 0);
    chk("ch_rdy", ch_rdy, exp_rdy);
    chk("tx_ctl", {tx_vld, tx_sop, tx_eop, tx_mty}, {ev, esop, eeop, emty});
    chk("tx_data", tx_data, ed);
    if (ph != 0) begin
      chk("cur_ch", cur_ch, m_ch);
      chk("cfg_sport", cfg_sport, sport_tbl[m_ch*16 +: 16]);
      chk("cfg_dport", cfg_dport, dport_tbl[m_ch*16 +: 16]);
    end
    chk("timeout", timeout, exp_to);
    chk("err_proto", err_proto, exp_err);
    exp_to  = 1'b0;
    exp_err = exp_err | (ch_vld & ~ch_sop & ~gmask);
    case (ph)
      0: begin
        rq = ch_vld & ch_sop;
        if (|rq) begin
          m_ch = rr(m_last, rq); m_last = m_ch; grants.push_back(m_ch); ph = 1;
        end
      end
      1: if (ev) begin
        nvld++;
        if (eeop) begin
          ph = 2; wcnt = 0;
          done_cnt = done_en ? int'($urandom_range(5, 1)) : 0;
          bi[m_ch] = 0; pi[m_ch]++;
        end else bi[m_ch]++;
      end
      default: begin
        if (pkt_done) ph = 0;
        else if (wcnt == TO - 1) begin ph = 0; exp_to = 1'b1; ntimeout++; end
        else wcnt++;
      end
    endcase
  endtask

  task automatic run(input int budget, input int stop_beats);
    int cyc; bit fin;
    cyc = 0; fin = 1'b0;
    while (!fin && cyc < budget) begin
      @(posedge clk); #1; drive();
      @(negedge clk); sample();
      cyc++;
      if (stop_beats > 0) fin = (nvld >= stop_beats);
      else                fin = all_done() && ph == 0;
    end
    chk("run_finish", fin, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_vld = '0; ch_sop = '0; ch_eop = '0; ch_mty = '0; ch_data = '0;
    tx_rdy = 1'b0; pkt_done = 1'b0;
    sport_tbl = {$urandom, $urandom};
    dport_tbl = {$urandom, $urandom};
    for (int c = 0; c < N; c++) begin npkt[c] = 0; pi[c] = 0; bi[c] = 0; bad[c] = 0; end
    vld_pct = 100; rdy_pct = 100; rdy_tog = 0; done_en = 1;
    ph = 0; m_ch = 0; m_last = N - 1; wcnt = 0; done_cnt = 0;
    nvld = 0; ntimeout = 0; total = 0; exp_to = 0; exp_err = '0;
    grants.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cur_ch", cur_ch, 2'd0);
    chk("rst_cfg", {cfg_sport, cfg_dport}, 32'h0);
    chk("rst_err", err_proto, 4'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_outs", {ch_rdy, tx_vld}, 5'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    // single 5-beat packet on ch0, one-byte tail
    do_reset();
    sport_tbl[15:0] = 16'h1234;
    add_pkt(0, 5, 1'b1);
    run(200, 0);
    chk("t1_grants", grants.size(), 1);
    chk("t1_beats", nvld, 5);

    // all channels contend, three packets each
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++) add_pkt(c, $urandom_range(6, 1), 1'($urandom_range(1)));
    rdy_pct = 80;
    run(1000, 0);
    chk("t2_grants", grants.size(), 12);
    for (int g = 0; g < grants.size(); g++) chk("t2_order", grants[g], g % N);

    // alternating tx_rdy during an 8-beat ch2 packet
    do_reset();
    add_pkt(2, 8, 1'b0);
    rdy_tog = 1'b1;
    run(200, 0);
    chk("t3_beats", nvld, 8);
    chk("t3_grant", grants[0], 2);

    // ch1 streams non-sop beats while idle; ch3 must still be served
    do_reset();
    bad[1] = 1'b1;
    add_pkt(3, 3, 1'b1);
    run(200, 0);
    chk("t4_err", err_proto, 4'b0010);
    chk("t4_grants", grants.size(), 1);
    chk("t4_grant", grants[0], 3);

    // packer never reports done: watchdog releases each packet
    do_reset();
    done_en = 1'b0;
    add_pkt(0, 2, 1'b0);
    add_pkt(0, 3, 1'b1);
    run(300, 0);
    chk("t5_timeouts", ntimeout, 2);
    chk("t5_grants", grants.size(), 2);

    // reset asserted while beat 3 of a 6-beat packet is on the bus
    do_reset();
    add_pkt(0, 6, 1'b0);
    run(100, 3);
    chk("t6_mid_vld", tx_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", ch_rdy, 4'b0);
    chk("t6_rst_vld", tx_vld, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_cfg", cfg_sport, 16'h0);
    do_reset();
    add_pkt(1, 2, 1'b0);
    add_pkt(0, 6, 1'b1);
    run(200, 0);
    chk("t6_first", grants[0], 0);
    chk("t6_second", grants[1], 1);

    // long random mix
    do_reset();
    for (int c = 0; c < N; c++) begin
      int np;
      np = $urandom_range(6, 2);
      for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(8, 1), 1'($urandom_range(1)));
    end
    vld_pct = 70; rdy_pct = 70;
    run(5000, 0);
    chk("t7_beats", nvld, total);
    chk("t7_timeouts", ntimeout, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
